// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and a busy scoreboard
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]    raddr,
  output logic [NREAD*DATA_WIDTH-1:0]    rdata,
  output logic [NREAD-1:0]               rbusy,
  input  logic [NWRITE-1:0]              wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0]   waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0]   wdata,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]     busy_vec
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rd;
  logic                  whit, ahit;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction

  // later ports overwrite earlier ones, so the highest-index port wins conflicts
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++)
      if (wen[j] && !is_zero(waddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
        regs_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        busy_d[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    if (alloc_en && !is_zero(alloc_addr)) busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end

  // a same-cycle alloc keeps the register busy even when a write is forwarded
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    whit  = 1'b0;
    ahit  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra   = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd   = regs_q[ra];
      whit = 1'b0;
      for (int j = 0; j < NWRITE; j++)
        if (BYPASS != 0 && wen[j] && waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
          whit = 1'b1;
          rd   = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      ahit = alloc_en && alloc_addr == ra;
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = (rst || is_zero(ra)) ? '0 : rd;
      rbusy[i] = !rst && busy_q[ra] && !(whit && !ahit);
    end
  end

  assign busy_vec = rst ? '0 : busy_q;

`ifdef SIM_TRACE
  function automatic logic superseded(input int j);
    for (int k = j + 1; k < NWRITE; k++)
      if (wen[k] && waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == waddr[j*ADDR_WIDTH +: ADDR_WIDTH]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk)
    if (!rst)
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && !is_zero(waddr[j*ADDR_WIDTH +: ADDR_WIDTH]) && !superseded(j))
          $display("regfile_mp write: port %0d addr %0d data %h", j,
                   waddr[j*ADDR_WIDTH +: ADDR_WIDTH], wdata[j*DATA_WIDTH +: DATA_WIDTH]);
`endif
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
- Successor to the single-write, two-read register file of the LemonPC core.
- Serves decode and writeback of a multi-issue pipeline.
- Provides NREAD combinational read ports, NWRITE synchronous write ports with fixed priority, an optional hardwired-zero register 0, and pending-write tracking for hazard detection.

Parameters:
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width in bits.
- NREAD, 2, number of read ports (1..8).
- NWRITE, 1, number of write ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NREAD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NREAD*DATA_WIDTH  read data, same packing.
- rbusy  out  NREAD  1 = register addressed by port i has a pending write.
- wen  in  NWRITE  write enables.
- waddr  in  NWRITE*ADDR_WIDTH  write addresses.
- wdata  in  NWRITE*DATA_WIDTH  write data.
- alloc_en  in  1  mark a register as pending (instruction issued).
- alloc_addr  in  ADDR_WIDTH  register to mark.
- busy_vec  out  2**ADDR_WIDTH  raw scoreboard bits, for debug.

Behaviour:
Reset:
- rst high clears every register to 0 and every busy bit to 0, immediately and independent of clk.
- While rst is high: writes and alloc are ignored, bypass is disabled, rdata is all 0, rbusy is 0, busy_vec is 0.
- Reset asserted mid-write: the write is lost, and the register stays 0 after release.

Write:
- At posedge, for each port j with wen[j]=1, reg[waddr[j]] <= wdata[j].
- Address conflict: two or more enabled ports targeting the same register -> the highest-index port wins, and the others are dropped silently.
- ZERO_REG=1: writes to address 0 are discarded.

Read (combinational, zero latency):
- Base value: rdata[i] = reg[raddr[i]].
- BYPASS=1: if any enabled write port targets raddr[i] this cycle, rdata[i] = wdata of the highest-index such port.
- BYPASS=1 with ZERO_REG=1: address 0 is never bypassed.
- ZERO_REG=1 and raddr[i]=0: rdata[i] = 0 unconditionally.
- Ports are fully independent; any number may read the same address.

Scoreboard:
- busy[k] is set at posedge when alloc_en=1 and alloc_addr=k.
- busy[k] is cleared at posedge when any enabled write targets k.
- Simultaneous alloc and write to the same k: set wins, since the newer producer still pends.
- ZERO_REG=1: alloc to 0 is ignored and busy[0] is constant 0.
- rbusy[i] = busy[raddr[i]], except with BYPASS=1 rbusy[i] = 0 when a same-cycle write to raddr[i] is enabled and no same-cycle alloc targets it.
- Alloc to an already busy register: stays busy; no counting, one outstanding write per register.
- A write to a non-busy register is legal: data is stored and busy stays 0.

Widths:
- No arithmetic.
- Addresses are full-range; all 2**ADDR_WIDTH entries exist.

Simulation:
- Under the SIM_TRACE define only, print one line per committed write: port, address, data.
- Trace output must not affect synthesis.

Test Plan:
- Reset: load regs 1..31 = index*0x11, pulse rst between clock edges -> all rdata = 0 without waiting for a clk edge, busy_vec = 0; after release, reading reg 5 gives 0.
- Zero register: wen[0]=1, waddr=0, wdata=0xDEADBEEF, then read addr 0 -> 0; alloc_addr=0 -> busy_vec[0] stays 0.
- Conflict (NWRITE=2): both ports write reg 7, port0 = 0x1111, port1 = 0x2222 -> next cycle reg 7 = 0x2222; same cycle with BYPASS=1, rdata for addr 7 = 0x2222.
- Bypass vs. no bypass: reg 3 = 0xA, write 0xB to reg 3 while reading it -> BYPASS=1 gives 0xB combinationally; BYPASS=0 gives 0xA, then 0xB next cycle.
- Scoreboard: alloc reg 9 -> rbusy = 1 next cycle; write reg 9 = 0x55 -> rbusy drops combinationally (BYPASS=1) and busy_vec[9] = 0 after the edge; alloc and write reg 9 in the same cycle -> busy_vec[9] = 1 after the edge.
- Multi-read (NREAD=4): all four ports read distinct regs 1..4 preloaded with 0x10..0x40, then all read reg 2 -> correct values on every port in the same cycle.
